// File: rtl/bit_correlator_if.sv
// Sample/code/result bundle between the NCO-side producer, the correlator and
// its downstream consumer.
interface bit_correlator_if #(
    parameter int LEN_W = 12,
    parameter int ACC_W = 16
);
    logic                    enable;
    logic                    sample;
    logic                    i_code;
    logic                    q_code;
    logic [LEN_W-1:0]        dump_len;
    logic signed [ACC_W-1:0] i_sum;
    logic signed [ACC_W-1:0] q_sum;
    logic                    valid;
    logic                    ready;
    logic                    overrun;

    modport master (
        output enable, sample, i_code, q_code, dump_len, ready,
        input  i_sum, q_sum, valid, overrun
    );

    modport slave (
        input  enable, sample, i_code, q_code, dump_len, ready,
        output i_sum, q_sum, valid, overrun
    );
endinterface

// File: rtl/bit_correlator.sv
// Integrate-and-dump correlator: multiplies 1-bit samples by the NCO I/Q codes,
// sums over an N-sample window and hands each result over a valid/ready register.
module bit_correlator #(
    parameter int LEN_W = 12,
    parameter int ACC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_correlator_if.slave bus
);
    generate
        if (ACC_W < LEN_W + 2) begin : g_width_check
            $error("bit_correlator: ACC_W must be at least LEN_W+2");
        end
    endgenerate

    localparam logic signed [ACC_W-1:0] ACC_ZERO    = {ACC_W{1'b0}};
    localparam logic signed [ACC_W-1:0] ACC_ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] ACC_NEG_ONE = {ACC_W{1'b1}};
    localparam logic [LEN_W-1:0]        LEN_ZERO    = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]        LEN_ONE     = {{(LEN_W-1){1'b0}}, 1'b1};

    logic                    r_en;
    logic                    r_smp;
    logic                    r_ic;
    logic                    r_qc;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_len;
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic signed [ACC_W-1:0] r_i_sum;
    logic signed [ACC_W-1:0] r_q_sum;
    logic                    r_valid;
    logic                    r_overrun;

    logic signed [ACC_W-1:0] w_pi;
    logic signed [ACC_W-1:0] w_pq;
    logic signed [ACC_W-1:0] w_acc_i_nx;
    logic signed [ACC_W-1:0] w_acc_q_nx;
    logic [LEN_W-1:0]        w_len_eff;
    logic [LEN_W-1:0]        w_len;
    logic [LEN_W-1:0]        w_cnt_inc;
    logic                    w_start;
    logic                    w_dump;

    assign w_pi       = (r_smp ~^ r_ic) ? ACC_ONE : ACC_NEG_ONE;
    assign w_pq       = (r_smp ~^ r_qc) ? ACC_ONE : ACC_NEG_ONE;
    assign w_acc_i_nx = r_acc_i + w_pi;
    assign w_acc_q_nx = r_acc_q + w_pq;
    assign w_start    = (r_cnt == LEN_ZERO);
    assign w_cnt_inc  = r_cnt + LEN_ONE;
    assign w_dump     = r_en && (w_cnt_inc == w_len);

    // Window length: a zero request means one sample; latched value is used after the first sample.
    always_comb begin
        w_len_eff = bus.dump_len;
        w_len     = r_len;
        if (bus.dump_len == LEN_ZERO) begin
            w_len_eff = LEN_ONE;
        end else begin
            w_len_eff = bus.dump_len;
        end
        if (w_start) begin
            w_len = w_len_eff;
        end else begin
            w_len = r_len;
        end
    end

    // Input pipeline stage capturing the qualifier, sample and NCO codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en  <= 1'b0;
            r_smp <= 1'b0;
            r_ic  <= 1'b0;
            r_qc  <= 1'b0;
        end else begin
            r_en  <= bus.enable;
            r_smp <= bus.sample;
            r_ic  <= bus.i_code;
            r_qc  <= bus.q_code;
        end
    end

    // Accumulators and window counter; they restart on the dump edge so no sample is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= LEN_ZERO;
            r_len   <= LEN_ONE;
            r_acc_i <= ACC_ZERO;
            r_acc_q <= ACC_ZERO;
        end else if (r_en) begin
            if (w_start) begin
                r_len <= w_len_eff;
            end
            if (w_dump) begin
                r_cnt   <= LEN_ZERO;
                r_acc_i <= ACC_ZERO;
                r_acc_q <= ACC_ZERO;
            end else begin
                r_cnt   <= w_cnt_inc;
                r_acc_i <= w_acc_i_nx;
                r_acc_q <= w_acc_q_nx;
            end
        end
    end

    // Result register with valid/ready handshake; overwriting an unaccepted result sets the sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_sum   <= ACC_ZERO;
            r_q_sum   <= ACC_ZERO;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_dump) begin
            r_i_sum <= w_acc_i_nx;
            r_q_sum <= w_acc_q_nx;
            r_valid <= 1'b1;
            if (r_valid && !bus.ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && bus.ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.i_sum   = r_i_sum;
    assign bus.q_sum   = r_q_sum;
    assign bus.valid   = r_valid;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_bit_correlator.sv
// Self-checking bench for bit_correlator: table-driven windows, directed corner
// sequences and randomized traffic against a window-list reference model.
module tb_bit_correlator;
    localparam int LEN_W = 12;
    localparam int ACC_W = 16;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    bit_correlator_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    bit_correlator #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: products of the current window kept as lists.
    int   win_i[$];
    int   win_q[$];
    int   m_len;
    int   m_i;
    int   m_q;
    bit   m_valid;
    bit   m_ovr;
    bit   p_en, p_smp, p_ic, p_qc;

    task automatic model_reset();
        win_i.delete();
        win_q.delete();
        m_len = 1; m_i = 0; m_q = 0; m_valid = 1'b0; m_ovr = 1'b0;
        p_en = 1'b0; p_smp = 1'b0; p_ic = 1'b0; p_qc = 1'b0;
    endtask

    task automatic model_edge();
        bit dump;
        int si, sq;
        dump = 1'b0;
        si = 0;
        sq = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (p_en) begin
                if (win_i.size() == 0)
                    m_len = (bus.dump_len == 12'd0) ? 1 : int'(bus.dump_len);
                win_i.push_back((p_smp == p_ic) ? 1 : -1);
                win_q.push_back((p_smp == p_qc) ? 1 : -1);
                if (win_i.size() == m_len) begin
                    foreach (win_i[k]) si += win_i[k];
                    foreach (win_q[k]) sq += win_q[k];
                    win_i.delete();
                    win_q.delete();
                    dump = 1'b1;
                end
            end
            if (dump) begin
                if (m_valid && !bus.ready) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_i = si;
                m_q = sq;
            end else if (m_valid && bus.ready) begin
                m_valid = 1'b0;
            end
            p_en = bus.enable; p_smp = bus.sample; p_ic = bus.i_code; p_qc = bus.q_code;
        end
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"},   bus.valid,          m_valid);
        chk({tag, ".overrun"}, bus.overrun,        m_ovr);
        chk({tag, ".i_sum"},   $signed(bus.i_sum), m_i);
        chk({tag, ".q_sum"},   $signed(bus.q_sum), m_q);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input bit en, input bit s, input bit ic, input bit qc);
        bus.enable = en; bus.sample = s; bus.i_code = ic; bus.q_code = qc;
    endtask

    typedef struct {
        int         len;
        logic [7:0] s;
        logic [7:0] ic;
        logic [7:0] qc;
        int         ei;
        int         eq;
    } win_t;

    win_t tbl[6];

    initial begin
        int pulses;
        n_vec = 0;
        n_err = 0;
        model_reset();

        tbl[0] = '{len: 8, s: 8'hFF, ic: 8'hFF, qc: 8'h00, ei:  8, eq: -8};
        tbl[1] = '{len: 4, s: 8'h05, ic: 8'h0F, qc: 8'h05, ei:  0, eq:  4};
        tbl[2] = '{len: 3, s: 8'h02, ic: 8'h07, qc: 8'h00, ei: -1, eq:  1};
        tbl[3] = '{len: 1, s: 8'h01, ic: 8'h00, qc: 8'h01, ei: -1, eq:  1};
        tbl[4] = '{len: 0, s: 8'h00, ic: 8'h00, qc: 8'h01, ei:  1, eq: -1};
        tbl[5] = '{len: 5, s: 8'h1F, ic: 8'h00, qc: 8'h1F, ei: -5, eq:  5};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        bus.dump_len = 12'd8;
        bus.ready    = 1'b0;
        #1;
        chk("reset.valid",   bus.valid,          0);
        chk("reset.overrun", bus.overrun,        0);
        chk("reset.i_sum",   $signed(bus.i_sum), 0);
        chk("reset.q_sum",   $signed(bus.q_sum), 0);
        step("reset");
        step("reset");
        rst_n = 1'b1;
        bus.ready = 1'b1;
        step("idle");

        // Table-driven complete windows, ready held high.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = (tbl[r].len == 0) ? 1 : tbl[r].len;
            bus.dump_len = tbl[r].len[LEN_W-1:0];
            for (int k = 0; k < n; k++) begin
                drive(1'b1, tbl[r].s[k], tbl[r].ic[k], tbl[r].qc[k]);
                step("tbl");
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            step("tbl");
            chk("tbl.valid", bus.valid, 1);
            chk("tbl.i_sum", $signed(bus.i_sum), tbl[r].ei);
            chk("tbl.q_sum", $signed(bus.q_sum), tbl[r].eq);
            step("tbl");
        end

        // Back-to-back N=4 windows with continuous ready.
        bus.dump_len = 12'd4;
        pulses = 0;
        for (int k = 0; k < 13; k++) begin
            if (k < 12) drive(1'b1, ~k[0], 1'b1, ~k[0]);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0);
            step("b2b");
            if (bus.valid) begin
                pulses++;
                chk("b2b.i_sum", $signed(bus.i_sum), 0);
                chk("b2b.q_sum", $signed(bus.q_sum), 4);
            end
        end
        chk("b2b.pulses", pulses, 3);

        // Gaps in enable stretch the window.
        for (int k = 0; k < 7; k++) begin
            drive(!k[0], 1'b1, 1'b1, 1'b0);
            step("gap");
            chk("gap.no_early_valid", bus.valid, 0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("gap");
        chk("gap.valid", bus.valid, 1);
        chk("gap.i_sum", $signed(bus.i_sum), 4);
        chk("gap.q_sum", $signed(bus.q_sum), -4);
        step("gap");

        // Overrun: two N=2 windows with ready low.
        bus.ready = 1'b0;
        bus.dump_len = 12'd2;
        for (int k = 0; k < 4; k++) begin
            if (k < 2) drive(1'b1, 1'b1, 1'b1, 1'b1);
            else       drive(1'b1, 1'b1, 1'b0, 1'b0);
            step("ovr");
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("ovr");
        chk("ovr.valid",   bus.valid, 1);
        chk("ovr.overrun", bus.overrun, 1);
        chk("ovr.i_sum",   $signed(bus.i_sum), -2);
        chk("ovr.q_sum",   $signed(bus.q_sum), -2);
        bus.ready = 1'b1;
        step("ovr");
        chk("ovr.valid_drop",   bus.valid, 0);
        chk("ovr.overrun_kept", bus.overrun, 1);

        // Asynchronous reset mid-window, then a clean window.
        bus.dump_len = 12'd8;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            step("mid");
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("mid");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.overrun", bus.overrun, 0);
        chk("arst.i_sum",   $signed(bus.i_sum), 0);
        chk("arst.q_sum",   $signed(bus.q_sum), 0);
        step("arst");
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            step("post");
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("post");
        chk("post.valid", bus.valid, 1);
        chk("post.i_sum", $signed(bus.i_sum), 8);
        chk("post.q_sum", $signed(bus.q_sum), -8);
        step("post");

        // dump_len=0 dumps every sample; then 8 -> 3 change mid-window.
        bus.dump_len = 12'd0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, k[0], 1'b1, 1'b0);
            step("len0");
            if (k > 0) chk("len0.valid", bus.valid, 1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("len0");
        step("len0");
        bus.dump_len = 12'd8;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 11) drive(1'b1, 1'b1, 1'b1, 1'b0);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0);
            step("lenchg");
            if (k == 1) bus.dump_len = 12'd3;
            if (bus.valid) pulses++;
            if (k == 8) chk("lenchg.i_sum8", $signed(bus.i_sum), 8);
            if (k == 11) chk("lenchg.i_sum3", $signed(bus.i_sum), 3);
        end
        chk("lenchg.pulses", pulses, 2);
        step("lenchg");

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            drive($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(1));
            bus.ready = ($urandom_range(2) != 0);
            if ($urandom_range(24) == 0) bus.dump_len = 12'($urandom_range(0, 9));
            if ($urandom_range(399) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all("rnd_arst");
                step("rnd_arst");
                rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
